// File: rtl/exec_stage.sv
// Registered execute stage: ALU control decode, 32-bit ALU, PC+4 and branch-target adders.
// Every result is captured in a single output register bank; latency is one cycle.
module exec_stage (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] pc,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [1:0]  aluop,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [15:0] imm,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned IMM_W  = 16;

    localparam logic [CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [CTRL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;

    logic [CTRL_W-1:0] ctrl_c;
    logic [DATA_W-1:0] result_c;
    logic              zero_c;
    logic              less_c;
    logic [DATA_W-1:0] pc_plus4_c;
    logic [DATA_W-1:0] offset_c;
    logic [DATA_W-1:0] target_c;

    // ALU control decode; unknown funct/opcode fall back to ADD
    always_comb begin
        ctrl_c = ALU_ADD;
        unique case (aluop)
            2'b00: ctrl_c = ALU_ADD;
            2'b01: ctrl_c = ALU_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  ctrl_c = ALU_ADD;
                    FN_SUB:  ctrl_c = ALU_SUB;
                    FN_AND:  ctrl_c = ALU_AND;
                    FN_OR:   ctrl_c = ALU_OR;
                    FN_SLT:  ctrl_c = ALU_SLT;
                    default: ctrl_c = ALU_ADD;
                endcase
            end
            2'b11: begin
                case (opcode)
                    OP_ADDI: ctrl_c = ALU_ADD;
                    OP_ANDI: ctrl_c = ALU_AND;
                    OP_ORI:  ctrl_c = ALU_OR;
                    OP_SLTI: ctrl_c = ALU_SLT;
                    default: ctrl_c = ALU_ADD;
                endcase
            end
            default: ctrl_c = ALU_ADD;
        endcase
    end

    // ALU datapath; add/sub wrap modulo 2^32 with no flags
    always_comb begin
        less_c   = $signed(alu_a) < $signed(alu_b);
        result_c = alu_a + alu_b;
        case (ctrl_c)
            ALU_AND: result_c = alu_a & alu_b;
            ALU_OR:  result_c = alu_a | alu_b;
            ALU_ADD: result_c = alu_a + alu_b;
            ALU_SUB: result_c = alu_a - alu_b;
            ALU_SLT: result_c = DATA_W'(less_c);
            default: result_c = alu_a + alu_b;
        endcase
        zero_c = (result_c == '0);
    end

    // Address adders: word offset is sign-extended and shifted left by two
    always_comb begin
        pc_plus4_c = pc + DATA_W'(4);
        offset_c   = {{(DATA_W - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
        target_c   = pc_plus4_c + offset_c;
    end

    // Output register bank; reset clears zero as well as result
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            alu_ctrl      <= '0;
            result        <= '0;
            zero          <= 1'b0;
            pc_plus4      <= '0;
            branch_target <= '0;
        end else begin
            alu_ctrl      <= ctrl_c;
            result        <= result_c;
            zero          <= zero_c;
            pc_plus4      <= pc_plus4_c;
            branch_target <= target_c;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed plan items plus random operations
// checked against a behavioural model of the decode and arithmetic rules.
module tb_exec_stage;

    logic        Clock;
    logic        Reset;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [15:0] imm;
    logic [2:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic [31:0] pc4;
        logic [31:0] bt;
    } exp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [1:0]  aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
    } op_t;

    wire [99:0] obs = {alu_ctrl, result, zero, pc_plus4, branch_target};

    exec_stage dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .pc            (pc),
        .opcode        (opcode),
        .funct         (funct),
        .aluop         (aluop),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .imm           (imm),
        .alu_ctrl      (alu_ctrl),
        .result        (result),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: pick the operation by name, then evaluate with plain arithmetic
    function automatic exp_t model(input op_t o);
        exp_t        e;
        string       kind;
        logic signed [31:0] off;
        kind = "add";
        if (o.aluop == 2'b01) kind = "sub";
        else if (o.aluop == 2'b10) begin
            if (o.funct == 6'd32) kind = "add";
            else if (o.funct == 6'd34) kind = "sub";
            else if (o.funct == 6'd36) kind = "and";
            else if (o.funct == 6'd37) kind = "or";
            else if (o.funct == 6'd42) kind = "slt";
        end else if (o.aluop == 2'b11) begin
            if (o.opcode == 6'd8) kind = "add";
            else if (o.opcode == 6'd12) kind = "and";
            else if (o.opcode == 6'd13) kind = "or";
            else if (o.opcode == 6'd10) kind = "slt";
        end
        case (kind)
            "and":   begin e.ctrl = 3'd0; e.res = o.a & o.b; end
            "or":    begin e.ctrl = 3'd1; e.res = o.a | o.b; end
            "sub":   begin e.ctrl = 3'd6; e.res = 32'(o.a - o.b); end
            "slt":   begin e.ctrl = 3'd7;
                           e.res = ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0; end
            default: begin e.ctrl = 3'd2; e.res = 32'(o.a + o.b); end
        endcase
        e.zero = (e.res == 32'd0);
        e.pc4  = 32'(o.pc + 32'd4);
        off    = $signed(o.imm);
        e.bt   = 32'(e.pc4 + 32'(off * 4));
        return e;
    endfunction

    task automatic drive(input op_t o);
        pc = o.pc; opcode = o.opcode; funct = o.funct; aluop = o.aluop;
        alu_a = o.a; alu_b = o.b; imm = o.imm;
    endtask

    // Apply inputs away from the edge, clock once, sample just after the edge
    task automatic issue(input op_t o);
        @(negedge Clock);
        drive(o);
        @(posedge Clock);
        #1;
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.pc = $urandom; o.opcode = 6'($urandom); o.funct = 6'($urandom);
        o.aluop = 2'($urandom); o.a = $urandom; o.b = $urandom; o.imm = 16'($urandom);
        return o;
    endfunction

    task automatic test_reset();
        op_t o;
        exp_t e;
        Reset = 1'b0;
        drive(rand_op());
        repeat (2) @(posedge Clock);
        #1;
        total_cnt++;
        if (obs !== 100'd0) $display("FAIL reset_held_over_edge: got %h expected 0", obs);
        else pass_cnt++;
        o = rand_op();
        o.aluop = 2'b00; o.a = 32'h11; o.b = 32'h22;
        @(negedge Clock);
        Reset = 1'b1;
        issue(o);
        e = model(o);
        total_cnt++;
        if (obs !== e) $display("FAIL reset_release_load: got %h expected %h", obs, e);
        else pass_cnt++;
        #1;
        Reset = 1'b0;
        drive(rand_op());
        #1;
        total_cnt++;
        if (obs !== 100'd0) $display("FAIL reset_async_clear: got %h expected 0", obs);
        else pass_cnt++;
        #1;
        Reset = 1'b1;
        o = rand_op();
        o.pc = 32'd0;
        issue(o);
        total_cnt++;
        if (pc_plus4 !== 32'd4) $display("FAIL reset_first_pc4: got %h expected 00000004", pc_plus4);
        else pass_cnt++;
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [31:0] rv [5] = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd0};
        logic [2:0]  cv [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        op_t o;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            o = rand_op();
            o.aluop = 2'b10; o.funct = fn[i]; o.a = 32'd7; o.b = 32'd5;
            issue(o);
            e = model(o);
            total_cnt++;
            if (result !== rv[i] || alu_ctrl !== cv[i])
                $display("FAIL rtype_%0d: got ctrl=%b result=%h expected ctrl=%b result=%h",
                         i, alu_ctrl, result, cv[i], rv[i]);
            else pass_cnt++;
            total_cnt++;
            if (obs !== e) $display("FAIL rtype_model_%0d: got %h expected %h", i, obs, e);
            else pass_cnt++;
        end
        o.a = 32'hFFFF_FFFF; o.funct = 6'b101010;
        issue(o);
        total_cnt++;
        if (result !== 32'd1 || zero !== 1'b0)
            $display("FAIL rtype_slt_neg: got result=%h zero=%b expected 00000001 0", result, zero);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        op_t o;
        o = rand_op();
        o.aluop = 2'b01; o.a = 32'h1234; o.b = 32'h1234; o.funct = 6'b100101;
        issue(o);
        total_cnt++;
        if (result !== 32'd0 || zero !== 1'b1 || alu_ctrl !== 3'b110)
            $display("FAIL branch_equal: got result=%h zero=%b ctrl=%b expected 0 1 110",
                     result, zero, alu_ctrl);
        else pass_cnt++;
        o.a = 32'd3; o.b = 32'd4;
        issue(o);
        total_cnt++;
        if (result !== 32'hFFFF_FFFF || zero !== 1'b0)
            $display("FAIL branch_less: got result=%h zero=%b expected ffffffff 0", result, zero);
        else pass_cnt++;
    endtask

    task automatic test_imm();
        logic [5:0]  opc [4] = '{6'b001101, 6'b001100, 6'b001000, 6'b000000};
        logic [31:0] rv  [4] = '{32'h0FFF, 32'h000F, 32'h100E, 32'h100E};
        op_t o;
        o = rand_op();
        o.aluop = 2'b11; o.a = 32'h0F0F; o.b = 32'h00FF; o.funct = 6'b100010;
        for (int i = 0; i < 4; i++) begin
            o.opcode = opc[i];
            issue(o);
            total_cnt++;
            if (result !== rv[i]) $display("FAIL imm_%0d: got %h expected %h", i, result, rv[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_adders();
        op_t o;
        o = rand_op();
        o.pc = 32'h0040_0000; o.imm = 16'hFFFF;
        issue(o);
        total_cnt++;
        if (pc_plus4 !== 32'h0040_0004 || branch_target !== 32'h0040_0000)
            $display("FAIL adder_neg_imm: got pc4=%h bt=%h expected 00400004 00400000",
                     pc_plus4, branch_target);
        else pass_cnt++;
        o.imm = 16'h0003;
        issue(o);
        total_cnt++;
        if (branch_target !== 32'h0040_0010)
            $display("FAIL adder_pos_imm: got %h expected 00400010", branch_target);
        else pass_cnt++;
        o.pc = 32'hFFFF_FFFC; o.imm = 16'h0000;
        issue(o);
        total_cnt++;
        if (pc_plus4 !== 32'd0 || branch_target !== 32'd0)
            $display("FAIL adder_wrap: got pc4=%h bt=%h expected 0 0", pc_plus4, branch_target);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [5:0] fns [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        logic [5:0] ops [5] = '{6'd8, 6'd12, 6'd13, 6'd10, 6'd4};
        op_t o;
        exp_t e;
        for (int i = 0; i < 200; i++) begin
            o = rand_op();
            if ($urandom_range(0, 3) != 0) o.funct = fns[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) != 0) o.opcode = ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) o.b = o.a;
            issue(o);
            e = model(o);
            total_cnt++;
            if (obs !== e) $display("FAIL random_%0d: got %h expected %h", i, obs, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        op_t  ops [4];
        exp_t e;
        for (int i = 0; i < 4; i++) ops[i] = rand_op();
        for (int i = 0; i < 4; i++) begin
            issue(ops[i]);
            e = model(ops[i]);
            total_cnt++;
            if (obs !== e) $display("FAIL b2b_edge_%0d: got %h expected %h", i, obs, e);
            else pass_cnt++;
            if (i == 1) begin
                #1;
                Reset = 1'b0;
                #1;
                total_cnt++;
                if (obs !== 100'd0) $display("FAIL b2b_reset_clear: got %h expected 0", obs);
                else pass_cnt++;
                #1;
                Reset = 1'b1;
            end else if (i < 3) begin
                @(negedge Clock);
                drive(ops[i+1]);
                #1;
                total_cnt++;
                if (obs !== e) $display("FAIL b2b_hold_%0d: got %h expected %h", i, obs, e);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        Reset = 1'b0;
        drive(rand_op());
        test_reset();
        test_rtype();
        test_branch();
        test_imm();
        test_adders();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
